clk_en_sched: RTL and testbench
===============================

Name: clk_en_sched

Overview:
- Race-free sequencer for a two-stage capture chain: fast stage samples every cycle, slow stage samples once every P cycles.
- Produces clock-enable strobes on the single system clock; no derived or divided clocks.
- Owns the chain registers `q_d` and `d_out` and flags each slow-stage update with `d_valid`.
- Started and stopped by a host. The divide ratio is programmable and latched at start.

Parameters:
- `DIV_W`, 4, width of the divide-ratio input. Period is P = div + 2, so P ranges 2..2^DIV_W+1.
- `W`, 1, data width of the capture chain.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. All state clears immediately on assertion; release is synchronous to `clock`.
- `start`  in  1  request to begin sequencing; sampled only in IDLE.
- `stop`  in  1  request to end sequencing; sampled only in RUN.
- `div`  in  DIV_W  divide select, P = `div` + 2; latched on accepted start.
- `data`  in  W  input to the fast stage.
- `en_fast`  out  1  fast-stage enable; combinational decode of state.
- `en_slow`  out  1  slow-stage enable strobe; combinational decode of state and count.
- `q_d`  out  W  fast-stage register.
- `d_out`  out  W  slow-stage register.
- `d_valid`  out  1  registered pulse; high the cycle after each `en_slow`.
- `busy`  out  1  high when state != IDLE.

Behaviour:
- Reset values while `reset`=0, asynchronously: state=IDLE, cnt=0, div_lat=0, `q_d`=0, `d_out`=0, `d_valid`=0. Consequently `en_fast`=0, `en_slow`=0 and `busy`=0.
- State encoding: IDLE, RUN, DRAIN.
- Internal registers: cnt[DIV_W:0] and div_lat[DIV_W-1:0]. P_lat = div_lat + 2, computed at DIV_W+1 bits so there is no overflow.
- Transitions out of IDLE:
  - IDLE with `start`=1: next state RUN, cnt<=0, div_lat<=`div`.
  - `stop` is ignored in IDLE. `start` and `stop` asserted together in IDLE: start wins.
- Behaviour in RUN and DRAIN:
  - `start` is ignored.
  - `div` changes are ignored; div_lat holds its value.
  - cnt increments each cycle and wraps to 0 after reaching P_lat-1.
- Leaving RUN:
  - RUN with `stop`=1 and `en_slow`=0: next state DRAIN. The current period is completed.
  - RUN with `stop`=1 and `en_slow`=1: next state IDLE. That strobe is the final one.
- Leaving DRAIN: DRAIN with `en_slow`=1 gives next state IDLE, cnt<=0.
- Enable decodes:
  - `en_fast` = (state != IDLE).
  - `en_slow` = `en_fast` AND (cnt == P_lat-1).
- Strobe timing: the first `en_slow` occurs in the P-th cycle after start is accepted, counting the first RUN cycle as 1. Subsequent strobes follow every P cycles exactly.
- Datapath updates:
  - `q_d` <= `data` on an edge where `en_fast`=1; otherwise it holds.
  - `d_out` <= `q_d` on an edge where `en_slow`=1. It takes the pre-edge `q_d`, so there is no race: the slow stage sees the value captured at least one cycle earlier.
  - `d_valid` <= `en_slow` (one-cycle pulse, aligned with the new `d_out`).
- Reset asserted mid-RUN or mid-DRAIN: immediate return to the reset values. There is no final strobe.
- Boundary at P=2 (`div`=0): `en_slow` fires on alternate RUN cycles. This matches a divide-by-2 of `clock` without a derived clock.
- Boundary at `div` = all ones: P = 2^DIV_W+1, and cnt must reach 2^DIV_W without wrapping early.

Test Plan:
- Reset release, no start: hold `reset`=0 then 1 for 5 cycles -> `busy`=0, `en_fast`=0, `en_slow`=0, `q_d`=0, `d_out`=0, `d_valid`=0.
- Divide-by-2 run: `div`=0, pulse `start`, `data` toggles 1,0,1,0... every cycle -> `en_slow` high in RUN cycles 2,4,6. Each `d_out` equals the `data` value presented in the RUN cycle immediately preceding its `en_slow` (the pre-edge `q_d`). `d_valid` pulses in RUN cycles 3,5,7.
- Max ratio: `div`=15 (DIV_W=4) -> `en_slow` in RUN cycles 17 and 34 only. Changing `div` to 3 mid-run has no effect on the period.
- Stop with drain: P=5, assert `stop` in RUN cycle 2 -> DRAIN; `en_slow` fires in cycle 5, then IDLE; `busy` falls the next cycle. Total `en_slow` count = 1.
- Stop coincident with strobe: P=3, `stop` in RUN cycle 3 -> IDLE the next cycle, with no DRAIN state. `d_valid` pulses once after stop.
- Reset mid-operation and start priority:
  - Drop `reset` in RUN cycle 4 with P=4 -> outputs clear in the same cycle with no clock edge; no `en_slow` is emitted.
  - After release, `start`=`stop`=1 in IDLE -> enters RUN.

Source files
------------

// File: rtl/clk_en_sched.sv
// Clock-enable sequencer for a two-stage capture chain: the fast stage samples
// every active cycle, the slow stage once every P = div + 2 cycles.
module clk_en_sched #(
    parameter int DIV_W = 4,
    parameter int W     = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [W-1:0]     data,
    output logic             en_fast,
    output logic             en_slow,
    output logic [W-1:0]     q_d,
    output logic [W-1:0]     d_out,
    output logic             d_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W:0]   cnt, cnt_nxt;
    logic [DIV_W-1:0] div_lat, div_lat_nxt;
    logic [DIV_W:0]   cnt_last;

    // Last count of a period is P_lat-1 = div_lat+1; one extra bit avoids overflow.
    assign cnt_last = {1'b0, div_lat} + {{DIV_W{1'b0}}, 1'b1};

    assign en_fast = (state != IDLE);
    assign en_slow = en_fast && (cnt == cnt_last);
    assign busy    = en_fast;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_lat <= div_lat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_lat_nxt = div_lat;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    cnt_nxt     = '0;
                    div_lat_nxt = div;
                end
            end
            RUN: begin
                cnt_nxt = en_slow ? '0 : cnt + 1'b1;
                // A stop on the strobe cycle ends immediately; otherwise finish the period.
                if (stop) begin
                    state_nxt = en_slow ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                cnt_nxt = en_slow ? '0 : cnt + 1'b1;
                if (en_slow) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Slow stage takes the pre-edge fast-stage value, so there is no race between them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_d     <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            if (en_fast) begin
                q_d <= data;
            end
            if (en_slow) begin
                d_out <= q_d;
            end
            d_valid <= en_slow;
        end
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// Self-checking bench for clk_en_sched: directed scenarios plus random runs,
// compared against a period/modulo reference model and a d_out expected queue.
module tb_clk_en_sched;

    localparam int DIV_W = 4;
    localparam int W     = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [DIV_W-1:0] div   = '0;
    logic [W-1:0]     data  = '0;
    logic             en_fast, en_slow, d_valid, busy;
    logic [W-1:0]     q_d, d_out;

    clk_en_sched #(.DIV_W(DIV_W), .W(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .div     (div),
        .data    (data),
        .en_fast (en_fast),
        .en_slow (en_slow),
        .q_d     (q_d),
        .d_out   (d_out),
        .d_valid (d_valid),
        .busy    (busy)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard and reference model
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    bit           m_active, m_drain, m_dvalid;
    int           m_k, m_p;
    logic [W-1:0] m_q, m_dout;
    int           slow_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_drain  = 0;
        m_dvalid = 0;
        m_k      = 0;
        m_p      = 2;
        m_q      = '0;
        m_dout   = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic cycle(input bit st, input bit sp, input int dv, input logic [W-1:0] dt);
        bit           exp_slow;
        logic [W-1:0] e;
        @(negedge clock);
        start = st;
        stop  = sp;
        div   = dv[DIV_W-1:0];
        data  = dt;
        #1;
        exp_slow = m_active && (m_k % m_p == 0);
        check("en_fast", en_fast, m_active);
        check("en_slow", en_slow, exp_slow);
        check("busy", busy, m_active);
        check("q_d", q_d, m_q);
        check("d_out", d_out, m_dout);
        check("d_valid", d_valid, m_dvalid);
        if (d_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_d_out", d_out, e);
            end
        end
        if (en_slow) slow_seen++;

        m_dvalid = exp_slow;
        if (exp_slow) begin
            exp_q.push_back(m_q);
            m_dout = m_q;
        end
        if (m_active) m_q = dt;
        if (!m_active) begin
            if (st) begin
                m_active = 1;
                m_drain  = 0;
                m_k      = 1;
                m_p      = int'(dv[DIV_W-1:0]) + 2;
            end
        end else begin
            if (!m_drain && sp) begin
                if (exp_slow) m_active = 0;
                else          m_drain  = 1;
            end else if (m_drain && exp_slow) begin
                m_active = 0;
            end
            m_k++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, W'($urandom));
    endtask

    initial begin
        model_reset();
        slow_seen = 0;

        // reset release with no start
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_en_slow", en_slow, 0);
        reset = 1'b1;
        idle_cycles(5);

        // divide-by-2 with toggling data
        cycle(1, 0, 0, 0);
        slow_seen = 0;
        for (int i = 1; i <= 8; i++) cycle(0, 0, 0, W'(i % 2));
        check("div2_strobes", slow_seen, 4);
        cycle(0, 1, 0, 1);
        idle_cycles(4);

        // max ratio, div change mid-run ignored
        cycle(1, 0, 15, 0);
        slow_seen = 0;
        for (int i = 1; i <= 34; i++) cycle(0, 0, (i > 5) ? 3 : 15, W'($urandom));
        check("max_strobes", slow_seen, 2);
        cycle(0, 1, 3, 0);
        idle_cycles(20);

        // stop with drain, P=5
        cycle(1, 0, 3, 1);
        slow_seen = 0;
        for (int i = 1; i <= 8; i++) cycle(0, (i == 2), 3, W'($urandom));
        check("drain_strobes", slow_seen, 1);
        check("drain_idle", busy, 0);

        // stop coincident with strobe, P=3
        cycle(1, 0, 1, 0);
        slow_seen = 0;
        for (int i = 1; i <= 5; i++) cycle(0, (i == 3), 1, W'($urandom));
        check("coinc_strobes", slow_seen, 1);

        // reset mid-run, P=4, dropped in RUN cycle 4
        cycle(1, 0, 2, 1);
        for (int i = 1; i <= 3; i++) cycle(0, 0, 2, W'(i % 2));
        @(negedge clock);
        #1;
        check("pre_rst_en_slow", en_slow, 1);
        #1;
        reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_en_fast", en_fast, 0);
        check("async_en_slow", en_slow, 0);
        check("async_q_d", q_d, 0);
        check("async_d_out", d_out, 0);
        check("async_d_valid", d_valid, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // start wins over stop in IDLE
        cycle(1, 1, 2, 1);
        check("prio_busy_pre", busy, 0);
        idle_cycles(12);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)), W'($urandom));
        end
        idle_cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
